// File: rtl/my_alu_divider.sv
// rtl/my_alu_divider.sv - multicycle signed restoring divider, one quotient bit per clock.
// Optional remainder output enabled by defining DIV_REMAINDER_EN.
module my_alu_divider #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ctrl_DIV,
  input  logic [DATA_WIDTH-1:0] data_operandA,
  input  logic [DATA_WIDTH-1:0] data_operandB,
  output logic [DATA_WIDTH-1:0] data_result,
  output logic                  data_exception,
  output logic                  data_resultRDY,
`ifdef DIV_REMAINDER_EN
  output logic [DATA_WIDTH-1:0] data_remainder,
`endif
  output logic                  busy
);

  localparam logic [DATA_WIDTH-1:0] MIN_NEG  = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ALL_ONES = '1;
  localparam logic [DATA_WIDTH-1:0] ONE      = 1;
  localparam logic [DATA_WIDTH:0]   ONE_X    = 1;
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ITER, FIXUP, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0] quo_q, quo_d;
  logic [DATA_WIDTH-1:0] div_q, div_d;
  logic                  neg_quo_q, neg_quo_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  exc_q, exc_d;
`ifdef DIV_REMAINDER_EN
  logic                  neg_rem_q, neg_rem_d;
  logic [DATA_WIDTH-1:0] remout_q, remout_d;
`endif

  logic [DATA_WIDTH-1:0] abs_a, abs_b;
  logic [DATA_WIDTH:0]   r_shift, trial;
  logic                  div_zero, overflow;

  // Magnitudes stay unsigned, so |MIN_NEG| is represented exactly.
  assign abs_a = data_operandA[DATA_WIDTH-1] ? (~data_operandA + ONE) : data_operandA;
  assign abs_b = data_operandB[DATA_WIDTH-1] ? (~data_operandB + ONE) : data_operandB;

  assign div_zero = (data_operandB == '0);
  assign overflow = (data_operandA == MIN_NEG) && (data_operandB == ALL_ONES);

  // Shifted partial remainder is < 2|B|, so the difference fits in DATA_WIDTH+1 signed bits.
  assign r_shift = {rem_q, quo_q[DATA_WIDTH-1]};
  assign trial   = r_shift + ~{1'b0, div_q} + ONE_X;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      neg_quo_q <= 1'b0;
      result_q  <= '0;
      exc_q     <= 1'b0;
`ifdef DIV_REMAINDER_EN
      neg_rem_q <= 1'b0;
      remout_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      neg_quo_q <= neg_quo_d;
      result_q  <= result_d;
      exc_q     <= exc_d;
`ifdef DIV_REMAINDER_EN
      neg_rem_q <= neg_rem_d;
      remout_q  <= remout_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    neg_quo_d = neg_quo_q;
    result_d  = result_q;
    exc_d     = exc_q;
`ifdef DIV_REMAINDER_EN
    neg_rem_d = neg_rem_q;
    remout_d  = remout_q;
`endif
    case (state_q)
      IDLE: begin
        if (ctrl_DIV) begin
          div_d     = abs_b;
          quo_d     = abs_a;
          rem_d     = '0;
          cnt_d     = '0;
          neg_quo_d = data_operandA[DATA_WIDTH-1] ^ data_operandB[DATA_WIDTH-1];
`ifdef DIV_REMAINDER_EN
          neg_rem_d = data_operandA[DATA_WIDTH-1];
`endif
          if (div_zero) begin
            state_d  = DONE;
            result_d = '0;
            exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
            remout_d = data_operandA;
`endif
          end else if (overflow) begin
            state_d  = DONE;
            result_d = MIN_NEG;
            exc_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
            remout_d = '0;
`endif
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        // A negative trial restores the shifted remainder and shifts in a 0.
        quo_d = {quo_q[DATA_WIDTH-2:0], ~trial[DATA_WIDTH]};
        rem_d = trial[DATA_WIDTH] ? r_shift[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == LAST_CNT) begin
          state_d = FIXUP;
        end
      end
      FIXUP: begin
        result_d = neg_quo_q ? (~quo_q + ONE) : quo_q;
        exc_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
        remout_d = neg_rem_q ? (~rem_q + ONE) : rem_q;
`endif
        state_d  = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q != IDLE);
`ifdef DIV_REMAINDER_EN
  assign data_remainder = remout_q;
`endif

endmodule

// File: tb/tb_my_alu_divider.sv
// tb/tb_my_alu_divider.sv - randomized bench for my_alu_divider against an arithmetic reference model.
module tb_my_alu_divider;
  localparam int DW = 32;
  localparam logic [31:0] MINN = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
`ifdef DIV_REMAINDER_EN
  logic [31:0] data_remainder;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  my_alu_divider dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
`ifdef DIV_REMAINDER_EN
    .data_remainder (data_remainder),
`endif
    .busy           (busy)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic ref_div(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] q, output logic [31:0] r, output logic e);
    if (b == 32'd0) begin
      q = 32'd0; r = a; e = 1'b1;
    end else if (a == MINN && b == 32'hFFFF_FFFF) begin
      q = MINN; r = 32'd0; e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      e = 1'b0;
    end
  endtask

  // Reference model: an operation occupies the unit from its sample edge through its ready cycle.
  int          n = 0;
  bit          m_act = 1'b0;
  int          m_rdy = 0;
  logic [31:0] m_q, m_r, h_q = '0, h_r = '0;
  logic        m_e, h_e = 1'b0;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_act = 1'b0;
      h_q = '0; h_r = '0; h_e = 1'b0;
    end else begin
      n = n + 1;
      if (m_act && n == m_rdy + 1) begin
        m_act = 1'b0;
      end else if (!m_act && ctrl_DIV) begin
        ref_div(data_operandA, data_operandB, m_q, m_r, m_e);
        m_act = 1'b1;
        m_rdy = m_e ? n : n + DW + 1;
      end
      if (m_act && n == m_rdy) begin
        h_q = m_q; h_r = m_r; h_e = m_e;
      end
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("rdy", {31'd0, data_resultRDY}, {31'd0, m_act && n == m_rdy});
      chk("busy", {31'd0, busy}, {31'd0, m_act});
      chk("result", data_result, h_q);
      chk("exception", {31'd0, data_exception}, {31'd0, h_e});
`ifdef DIV_REMAINDER_EN
      chk("remainder", data_remainder, h_r);
`endif
    end
  end

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eq, input logic [31:0] er, input logic ee, input int elat);
    int  lat;
    bit  got;
    @(negedge clock);
    data_operandA = a; data_operandB = b; ctrl_DIV = 1'b1;
    lat = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      ctrl_DIV = 1'b0;
      lat++;
      if (data_resultRDY) got = 1'b1;
    end
    if (!got) begin
      chk({name, " timeout"}, 32'd0, 32'd1);
    end else begin
      chk({name, " latency"}, lat, elat);
      chk({name, " q"}, data_result, eq);
      chk({name, " exc"}, {31'd0, data_exception}, {31'd0, ee});
`ifdef DIV_REMAINDER_EN
      chk({name, " r"}, data_remainder, er);
`endif
      @(negedge clock);
      chk({name, " busy_fall"}, {31'd0, busy}, 32'd0);
      chk({name, " rdy_pulse"}, {31'd0, data_resultRDY}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] q, r, a, b;
    logic        e;
    int          pulses, lat;

    ref_div(32'd100, 32'd7, q, r, e);
    chk("model 100/7 q", q, 32'd14);
    chk("model 100/7 r", r, 32'd2);
    ref_div(32'hFFFF_FF9C, 32'd7, q, r, e);
    chk("model -100/7 q", q, 32'hFFFF_FFF2);
    chk("model -100/7 r", r, 32'hFFFF_FFFE);

    repeat (3) @(negedge clock);
    chk("reset result", data_result, 32'd0);
    chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset exc", {31'd0, data_exception}, 32'd0);
    reset = 1'b1;

    run("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
    run("-100/7", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
    run("100/-7", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0, 34);
    run("5/0", 32'd5, 32'd0, 32'd0, 32'd5, 1'b1, 1);
    run("min/-1", MINN, 32'hFFFF_FFFF, MINN, 32'd0, 1'b1, 1);
    run("min/1", MINN, 32'd1, MINN, 32'd0, 1'b0, 34);
    run("max/max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 34);

    // Second start while busy must be ignored.
    @(negedge clock);
    data_operandA = 32'd1000; data_operandB = 32'd10; ctrl_DIV = 1'b1;
    pulses = 0; lat = 0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clock);
      ctrl_DIV = (i == 4);
      if (i == 4) begin data_operandA = 32'd9; data_operandB = 32'd3; end
      if (data_resultRDY) begin
        pulses++;
        lat = i;
        chk("busy-ignore q", data_result, 32'd100);
      end
    end
    chk("busy-ignore pulses", pulses, 32'd1);
    chk("busy-ignore latency", lat, 32'd34);

    // Asynchronous reset in the middle of an operation.
    @(negedge clock);
    data_operandA = 32'd1000; data_operandB = 32'd10; ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort result", data_result, 32'd0);
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort rdy", {31'd0, data_resultRDY}, 32'd0);
    chk("abort exc", {31'd0, data_exception}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    chk("abort no rdy", pulses, 32'd0);
    reset = 1'b1;
    run("9/3 after reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    // Start held high: back-to-back operations, checked by the model every cycle.
    @(negedge clock);
    data_operandA = 32'hFFFF_FC18; data_operandB = 32'd7; ctrl_DIV = 1'b1;
    pulses = 0;
    for (int i = 0; i < 75; i++) begin
      @(negedge clock);
      if (data_resultRDY) pulses++;
    end
    ctrl_DIV = 1'b0;
    chk("held start pulses", pulses, 32'd2);
    repeat (40) @(negedge clock);

    for (int k = 0; k < 150; k++) begin
      int kind;
      kind = $urandom_range(0, 9);
      a = $urandom();
      b = $urandom();
      if ($urandom_range(0, 7) == 0) a = MINN;
      case (kind)
        0: b = 32'd0;
        1: begin a = MINN; b = 32'hFFFF_FFFF; end
        2, 3: b = 32'($signed($urandom_range(0, 40)) - 20);
        4: b = b >> $urandom_range(1, 30);
        default: ;
      endcase
      ref_div(a, b, q, r, e);
      run("random", a, b, q, r, e, e ? 1 : 34);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/my_alu_divider.md
Name: my_ALU_divider

Overview:
- Multicycle signed 32-bit integer divider; the subtractive counterpart to the ALU's single-cycle CLA adder path.
- Sits beside the ALU in the execute stage. The pipeline stalls from `ctrl_DIV` until `data_resultRDY`.
- Uses restoring division, one quotient bit per clock: shift, trial-subtract, restore.

Parameters:
- DATA_WIDTH, 32, operand/quotient width; the iteration count equals DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.

Ports:
- clock  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- ctrl_DIV  input  1  start pulse; sampled only in IDLE.
- data_operandA  input  DATA_WIDTH  dividend, two's complement; sampled with ctrl_DIV.
- data_operandB  input  DATA_WIDTH  divisor, two's complement; sampled with ctrl_DIV.
- data_result  output  DATA_WIDTH  quotient, truncated toward zero.
- data_exception  output  1  divide-by-zero or overflow flag; valid with data_resultRDY.
- data_resultRDY  output  1  one-cycle pulse; result and flag valid while it is high.
- data_remainder  output  DATA_WIDTH  remainder; present only with DIV_REMAINDER_EN.
- busy  output  1  high from the sample edge until the RDY cycle, inclusive.

Behaviour:
- Reset (reset=0, async):
  - State goes to IDLE.
  - data_result, data_remainder, data_exception, data_resultRDY, busy, counter and all internal registers go to 0.
  - A reset mid-operation aborts it; no RDY pulse is issued for the aborted operation.
- States: IDLE, ITER, FIXUP, DONE.
- IDLE:
  - On an edge with ctrl_DIV=1: latch |A|, |B|, sign_q = A[31]^B[31], sign_r = A[31]. Set counter=0 and busy=1.
  - If B==0: go to DONE with result=0, remainder=A, exception=1. RDY is high in the cycle after the sample edge.
  - Else if A==0x80000000 and B==0xFFFFFFFF: go to DONE with result=0x80000000, remainder=0, exception=1.
  - Otherwise go to ITER.
- ITER (DATA_WIDTH cycles), per edge:
  - {R,Q} shifts left by 1.
  - trial = R - |B|, computed as R + ~|B| + 1 (same adder structure as the ALU).
  - If trial is non-negative: R=trial and Q[0]=1; else R is kept and Q[0]=0.
  - counter increments. Leave for FIXUP after the edge where counter==DATA_WIDTH-1.
- FIXUP (one edge):
  - result = sign_q ? -Q : Q.
  - remainder = sign_r ? -R : R.
  - exception = 0. Go to DONE.
- DONE (one cycle):
  - data_resultRDY=1. Next edge returns to IDLE with RDY=0 and busy=0.
  - data_result, data_remainder and data_exception hold their values until the next operation completes.
- Latency:
  - Normal: RDY is high in the cycle starting DATA_WIDTH+2 edges after the sample edge (34 for the default).
  - Exception fast path: RDY is high in the cycle starting 1 edge after the sample edge.
- ctrl_DIV while busy=1: ignored; operands are not re-sampled. ctrl_DIV in the DONE cycle is also ignored.
- ctrl_DIV held high continuously: a new operation starts on the first IDLE edge after DONE.
- Arithmetic rules:
  - |0x80000000| is represented as unsigned 0x80000000, so the internal datapath is DATA_WIDTH+1 bits wide.
  - The remainder sign follows the dividend. The identity A == Q*B + R holds for all non-exception cases.

Optional Feature:
- Macro: DIV_REMAINDER_EN.
- Defined: the data_remainder port exists and is driven as specified above.
- Undefined: the port is absent and the remainder sign-fixup logic is removed. R is still kept internally for the iteration. Quotient, flag and latency are identical in both builds.

Test Plan:
- A=100, B=7, pulse ctrl_DIV: RDY at edge+34; result=14; remainder=2; exception=0; busy falls the cycle after RDY.
- A=-100 (0xFFFFFF9C), B=7: result=0xFFFFFFF2 (-14); remainder=0xFFFFFFFE (-2). A=100, B=-7: result=-14, remainder=2.
- A=5, B=0: RDY one edge after the sample; result=0; exception=1; remainder=5. Then A=0x80000000, B=0xFFFFFFFF: result=0x80000000, exception=1.
- A=0x80000000, B=1: result=0x80000000, exception=0, latency 34. A=0x7FFFFFFF, B=0x7FFFFFFF: result=1, remainder=0.
- Start 1000/10. At edge+5 pulse ctrl_DIV with 9/3: ignored. RDY at edge+34 gives result=100. Exactly one RDY pulse.
- Start 1000/10. Drive reset=0 asynchronously at edge+12: all outputs 0 immediately, no RDY. After release, 9/3 gives result=3 at its edge+34.
